// File: rtl/button_event_arbiter_pkg.sv
// Shared constants for the button event arbiter: channel-count default,
// index-width derivation and the edge-type encoding carried on evt_rising.
package button_event_arbiter_pkg;

    localparam int NUM_CH_DEFAULT = 4;

    localparam logic EDGE_RISING  = 1'b1;
    localparam logic EDGE_FALLING = 1'b0;

    // Index width for 2..8 channels; a 2-channel build still needs one bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_event_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans requests starting at ptr,
// wrapping at NUM_CH-1, and returns the first hit as one-hot and as an index.
module rr_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              found
);

    logic [CH_W:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, ptr} + (CH_W + 1)'(i);
            if (cand >= (CH_W + 1)'(NUM_CH)) begin
                cand = cand - (CH_W + 1)'(NUM_CH);
            end
            if (!found && req[cand[CH_W-1:0]]) begin
                found                  = 1'b1;
                grant[cand[CH_W-1:0]]  = 1'b1;
                idx                    = cand[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Collects per-channel edge pulses into one-deep pending slots and serialises
// them round-robin onto a single valid/ready event register, flagging lost events.
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] pos_edge,
    input  logic [NUM_CH-1:0] neg_edge,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_chan,
    output logic              evt_rising,
    output logic [NUM_CH-1:0] overrun,
    input  logic              overrun_clr
);

    logic [NUM_CH-1:0] pend_valid;
    logic [NUM_CH-1:0] pend_rise;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] granted;
    logic [NUM_CH-1:0] new_edge;
    logic [NUM_CH-1:0] ovr_set;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   ptr_next;
    logic              grant_found;
    logic              can_load;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr (
        .req   (pend_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .found (grant_found)
    );

    // The output register can take a new event when empty or being drained.
    assign can_load = !evt_valid || evt_ready;
    assign granted  = can_load ? grant : '0;
    assign new_edge = pos_edge | neg_edge;
    assign ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    // Lost event: slot still occupied and not leaving, or both edges at once.
    assign ovr_set = (new_edge & pend_valid & ~granted) | (pos_edge & neg_edge);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= '0;
            pend_rise  <= '0;
            evt_valid  <= 1'b0;
            evt_chan   <= '0;
            evt_rising <= EDGE_FALLING;
            overrun    <= '0;
            ptr        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            for (int i = 0; i < NUM_CH; i++) begin
                if (new_edge[i]) begin
                    pend_valid[i] <= 1'b1;
                    pend_rise[i]  <= pos_edge[i] ? EDGE_RISING : EDGE_FALLING;
                end else if (granted[i]) begin
                    pend_valid[i] <= 1'b0;
                end
            end

            overrun <= (overrun & {NUM_CH{!overrun_clr}}) | ovr_set;

            if (can_load) begin
                if (grant_found) begin
                    evt_valid  <= 1'b1;
                    evt_chan   <= grant_idx;
                    evt_rising <= pend_rise[grant_idx];
                    ptr        <= ptr_next;
                end else if (evt_ready) begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: each task drives one scenario
// and compares outputs against hand-computed values one cycle at a time.
module tb_button_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] pos_edge;
    logic [NUM_CH-1:0] neg_edge;
    logic              evt_valid;
    logic              evt_ready;
    logic [CH_W-1:0]   evt_chan;
    logic              evt_rising;
    logic [NUM_CH-1:0] overrun;
    logic              overrun_clr;

    int total = 0;
    int bad   = 0;

    // {valid, chan[1:0], rising}
    wire [3:0] evt = {evt_valid, evt_chan, evt_rising};

    button_event_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .pos_edge    (pos_edge),
        .neg_edge    (neg_edge),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_chan    (evt_chan),
        .evt_rising  (evt_rising),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        pos_edge    = '0;
        neg_edge    = '0;
        overrun_clr = 1'b0;
        evt_ready   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
        total++;
        if (evt_chan !== 2'd0) begin bad++; $display("FAIL reset_chan got=%0d exp=0", evt_chan); end
        total++;
        if (evt_rising !== 1'b0) begin bad++; $display("FAIL reset_rising got=%b exp=0", evt_rising); end
        total++;
        if (overrun !== 4'b0000) begin bad++; $display("FAIL reset_overrun got=%b exp=0000", overrun); end
    endtask

    task automatic test_single();
        do_reset();
        evt_ready = 1'b1;
        pos_edge  = 4'b0100;
        tick();
        pos_edge = '0;
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", evt_valid); end
        tick();
        total++;
        if (evt !== 4'b1101) begin bad++; $display("FAIL single_evt got=%b exp=1101", evt); end
        tick();
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_drop got=%b exp=0", evt_valid); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b1000, 4'b1010, 4'b1100, 4'b1110};
        do_reset();
        evt_ready = 1'b1;
        neg_edge  = 4'b1111;
        tick();
        neg_edge = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (evt !== exp_seq[i]) begin bad++; $display("FAIL fair_evt%0d got=%b exp=%b", i, evt, exp_seq[i]); end
        end
        tick();
        total++;
        if ({evt_valid, overrun} !== 5'b0_0000) begin bad++; $display("FAIL fair_end got=%b exp=00000", {evt_valid, overrun}); end
    endtask

    task automatic test_backpressure();
        do_reset();
        pos_edge = 4'b1011;
        tick();
        pos_edge = '0;
        tick();
        total++;
        if (evt !== 4'b1001) begin bad++; $display("FAIL bp_first got=%b exp=1001", evt); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (evt !== 4'b1001) begin bad++; $display("FAIL bp_hold%0d got=%b exp=1001", i, evt); end
        end
        evt_ready = 1'b1;
        tick();
        total++;
        if (evt !== 4'b1011) begin bad++; $display("FAIL bp_drain1 got=%b exp=1011", evt); end
        tick();
        total++;
        if (evt !== 4'b1111) begin bad++; $display("FAIL bp_drain3 got=%b exp=1111", evt); end
        tick();
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", evt_valid); end
    endtask

    task automatic test_overrun();
        do_reset();
        // Park channel 0 in the output register so channel 1 stays pending.
        pos_edge = 4'b0001;
        tick();
        pos_edge = '0;
        tick();
        pos_edge = 4'b0010;
        tick();
        pos_edge = '0;
        tick();
        pos_edge = 4'b0010;
        tick();
        pos_edge = '0;
        total++;
        if ({evt, overrun} !== 8'b1001_0010) begin bad++; $display("FAIL ovr_set got=%b exp=10010010", {evt, overrun}); end
        evt_ready = 1'b1;
        tick();
        total++;
        if (evt !== 4'b1011) begin bad++; $display("FAIL ovr_evt got=%b exp=1011", evt); end
        tick();
        total++;
        if ({evt_valid, overrun} !== 5'b0_0010) begin bad++; $display("FAIL ovr_single got=%b exp=00010", {evt_valid, overrun}); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 4'b0000) begin bad++; $display("FAIL ovr_clear got=%b exp=0000", overrun); end
    endtask

    task automatic test_overwrite_clr();
        do_reset();
        pos_edge = 4'b0001;
        tick();
        pos_edge = '0;
        tick();
        neg_edge = 4'b0110;
        tick();
        neg_edge = '0;
        pos_edge = 4'b0010;
        tick();
        pos_edge = 4'b0100;
        overrun_clr = 1'b1;
        tick();
        pos_edge = '0;
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 4'b0100) begin bad++; $display("FAIL clr_race got=%b exp=0100", overrun); end
        evt_ready = 1'b1;
        tick();
        total++;
        if (evt !== 4'b1011) begin bad++; $display("FAIL ovw_ch1 got=%b exp=1011", evt); end
        tick();
        total++;
        if (evt !== 4'b1101) begin bad++; $display("FAIL ovw_ch2 got=%b exp=1101", evt); end
        tick();
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovw_end got=%b exp=0", evt_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        evt_ready = 1'b1;
        pos_edge  = 4'b1000;
        neg_edge  = 4'b1000;
        tick();
        pos_edge = '0;
        neg_edge = '0;
        total++;
        if (overrun !== 4'b1000) begin bad++; $display("FAIL simul_ovr got=%b exp=1000", overrun); end
        tick();
        total++;
        if (evt !== 4'b1111) begin bad++; $display("FAIL simul_evt got=%b exp=1111", evt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        evt_ready = 1'b1;
        pos_edge  = 4'b0001;
        tick();
        pos_edge = '0;
        neg_edge = 4'b0001;
        tick();
        neg_edge = '0;
        total++;
        if ({evt, overrun} !== 8'b1001_0000) begin bad++; $display("FAIL refill_first got=%b exp=10010000", {evt, overrun}); end
        tick();
        total++;
        if (evt !== 4'b1000) begin bad++; $display("FAIL refill_second got=%b exp=1000", evt); end
        tick();
        total++;
        if ({evt_valid, overrun} !== 5'b0_0000) begin bad++; $display("FAIL refill_end got=%b exp=00000", {evt_valid, overrun}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pos_edge = 4'b0111;
        tick();
        pos_edge = 4'b0010;
        tick();
        pos_edge = '0;
        total++;
        if ({evt, overrun} !== 8'b1001_0010) begin bad++; $display("FAIL mid_pre got=%b exp=10010010", {evt, overrun}); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({evt, overrun} !== 8'b0000_0000) begin bad++; $display("FAIL mid_reset got=%b exp=00000000", {evt, overrun}); end
        evt_ready = 1'b1;
        tick();
        total++;
        if (evt_valid !== 1'b0) begin bad++; $display("FAIL mid_flushed got=%b exp=0", evt_valid); end
        pos_edge = 4'b0010;
        tick();
        pos_edge = '0;
        tick();
        total++;
        if (evt !== 4'b1011) begin bad++; $display("FAIL mid_after got=%b exp=1011", evt); end
    endtask

    initial begin
        reset       = 1'b1;
        pos_edge    = '0;
        neg_edge    = '0;
        evt_ready   = 1'b0;
        overrun_clr = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_overrun();
        test_overwrite_clr();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of conditioned input channels; legal range 2..8.
REQ-002 Parameter CH_W, default 2: channel index width, equal to ceil(log2(NUM_CH)).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port pos_edge, input, NUM_CH: per-channel one-cycle rising-edge pulses from the input conditioners.
REQ-006 Port neg_edge, input, NUM_CH: per-channel one-cycle falling-edge pulses from the input conditioners.
REQ-007 Port evt_valid, output, 1: output event register holds an event.
REQ-008 Port evt_ready, input, 1: consumer accepts the event; transfer occurs when evt_valid and evt_ready are both 1.
REQ-009 Port evt_chan, output, CH_W: channel index of the presented event.
REQ-010 Port evt_rising, output, 1: 1 for a rising edge, 0 for a falling edge.
REQ-011 Port overrun, output, NUM_CH: sticky per-channel flag marking a lost event.
REQ-012 Port overrun_clr, input, 1: clears all overrun bits.

Function
REQ-013 Each channel SHALL hold one pending slot: a valid bit plus an edge-type bit.
REQ-014 An edge pulse sampled at rising edge k SHALL set that channel's pending slot, visible after edge k.
REQ-015 When the output register is empty or transferring, the block SHALL grant one pending channel per cycle, loading evt_chan/evt_rising and setting evt_valid at the next edge; minimum latency from edge pulse to evt_valid is 2 cycles.
REQ-016 Arbitration SHALL be round-robin: search starts at the channel after the last granted one, wrapping from NUM_CH-1 to 0.
REQ-017 Granting a channel SHALL clear its pending slot in the same edge.
REQ-018 While evt_valid=1 and evt_ready=0, evt_chan and evt_rising SHALL hold stable.
REQ-019 With evt_ready held 1 and events pending, throughput SHALL be one event per cycle.
REQ-020 A new edge arriving on a channel whose slot is valid and not granted that cycle SHALL overwrite the slot with the newer edge type and set that channel's overrun bit.
REQ-021 A new edge arriving in the same cycle that the channel is granted SHALL refill the slot without setting overrun.
REQ-022 Simultaneous pos_edge and neg_edge on one channel SHALL record a rising edge and set that channel's overrun bit.
REQ-023 overrun_clr SHALL clear all overrun bits; a new overrun in the same cycle SHALL win for its channel.
REQ-024 When no channel is pending and no transfer occurs, evt_valid SHALL remain unchanged.

Reset
REQ-025 On reset=1 at a clock edge, the block SHALL clear all pending slots and drive evt_valid=0, evt_chan=0, evt_rising=0, and overrun=0.
REQ-026 On reset, the round-robin pointer SHALL return to 0, so that channel 0 has first priority.
REQ-027 Reset SHALL override all inputs in that cycle; an event held mid-handshake SHALL be discarded.

Structure
REQ-028 The shared package SHALL hold the NUM_CH default, CH_W derivation, and edge-type encoding constants (RISING=1, FALLING=0).
REQ-029 The round-robin picker SHALL be a separate sub-module, rr_arbiter: NUM_CH request bits plus a pointer in, one-hot grant plus index out, purely combinational.
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 Single event: a pos_edge[2] pulse with ready=1 -> evt_valid=1 two cycles later with chan=2 and rising=1, held for 1 cycle.
REQ-032 Fairness: pulses on neg_edge[0..3] in the same cycle with ready=1 -> four consecutive events on chans 0,1,2,3, all falling, with no gaps.
REQ-033 Backpressure: ready=0 for 5 cycles with events pending -> evt_chan and evt_rising stable; after ready=1, remaining events drain in round-robin order.
REQ-034 Overrun: two pos_edge[1] pulses while ready=0 -> one event for chan 1 and overrun=0b0010; then overrun_clr -> overrun=0.
REQ-035 Simultaneous edges: pos_edge[3] and neg_edge[3] in one cycle -> event chan=3, rising=1, and overrun[3]=1.
REQ-036 Reset mid-operation: reset asserted while evt_valid=1 and events are pending -> next cycle all outputs 0; the next single pulse on chan 1 is granted normally.
